// File: rtl/cpu_mem_responder_if.sv
// CPU-side memory bus plus byte-serial loader port of the memory responder.
// master = CPU/boot source side, slave = responder side.
interface cpu_mem_responder_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] addr_0;
    logic [DATA_WIDTH-1:0] inst_out;
    logic [ADDR_WIDTH-1:0] addr_1;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  we_n;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  ld_start;
    logic                  ld_valid;
    logic [7:0]            ld_byte;
    logic                  ld_last;
    logic                  ld_ready;
    logic                  cpu_reset_n;
    logic                  load_done;

    modport master (
        output addr_0, addr_1, data_in, we_n,
        output ld_start, ld_valid, ld_byte, ld_last,
        input  inst_out, data_out, ld_ready, cpu_reset_n, load_done
    );

    modport slave (
        input  addr_0, addr_1, data_in, we_n,
        input  ld_start, ld_valid, ld_byte, ld_last,
        output inst_out, data_out, ld_ready, cpu_reset_n, load_done
    );
endinterface

// File: rtl/cpu_mem_responder.sv
// Instruction/data memories for the CPU with a byte-serial imem loader that holds the CPU in reset.
// Reads are combinational (0 cycles); loader accepts on ld_valid & ld_ready, ready only while loading.
module cpu_mem_responder #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
) (
    input logic clk,
    input logic reset_n,
    cpu_mem_responder_if.slave bus
);
    localparam int IA = $clog2(IMEM_DEPTH);
    localparam int DA = $clog2(DMEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] IMEM_LIM = IMEM_DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] DMEM_LIM = DMEM_DEPTH[ADDR_WIDTH:0];

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_HI = 3'd1,
        LOAD_LO = 3'd2,
        RELEASE = 3'd3,
        RUN     = 3'd4
    } state_t;

    state_t state_q, state_d;
    logic [IA-1:0] ld_addr_q, ld_addr_d;
    logic [7:0]    hi_reg_q, hi_reg_d;
    logic          load_done_q, load_done_d;

    logic          ld_ready;
    logic          cpu_reset_n;
    logic          imem_we;
    logic          accept;

    logic [DATA_WIDTH-1:0] imem_q [IMEM_DEPTH];
    logic [DATA_WIDTH-1:0] dmem_q [DMEM_DEPTH];

    logic i_hit, d_hit, d_we;

    assign i_hit  = {1'b0, bus.addr_0} < IMEM_LIM;
    assign d_hit  = {1'b0, bus.addr_1} < DMEM_LIM;
    assign d_we   = d_hit && !bus.we_n;
    assign accept = bus.ld_valid && ld_ready;

    // Out-of-range reads return zero, so the CPU's post-reset fetch at FFFF sees a NOP-like 0.
    assign bus.inst_out = i_hit ? imem_q[bus.addr_0[IA-1:0]] : '0;
    assign bus.data_out = d_we  ? bus.data_in :
                          d_hit ? dmem_q[bus.addr_1[DA-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (d_we) begin
            dmem_q[bus.addr_1[DA-1:0]] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem_q[ld_addr_q] <= {hi_reg_q, bus.ld_byte};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ld_addr_q   <= '0;
            hi_reg_q    <= '0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ld_addr_q   <= ld_addr_d;
            hi_reg_q    <= hi_reg_d;
            load_done_q <= load_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ld_addr_d   = ld_addr_q;
        hi_reg_d    = hi_reg_q;
        load_done_d = load_done_q;
        case (state_q)
            IDLE, RUN: begin
                if (bus.ld_start) begin
                    state_d   = LOAD_HI;
                    ld_addr_d = '0;
                end
            end
            LOAD_HI: begin
                if (accept) begin
                    hi_reg_d = bus.ld_byte;
                    state_d  = LOAD_LO;
                end
            end
            LOAD_LO: begin
                if (accept) begin
                    ld_addr_d = ld_addr_q + 1'b1;
                    state_d   = bus.ld_last ? RELEASE : LOAD_HI;
                end
            end
            RELEASE: begin
                state_d     = RUN;
                load_done_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ld_ready    = 1'b0;
        cpu_reset_n = 1'b0;
        imem_we     = 1'b0;
        case (state_q)
            LOAD_HI: ld_ready = 1'b1;
            LOAD_LO: begin
                ld_ready = 1'b1;
                imem_we  = bus.ld_valid;
            end
            RUN:     cpu_reset_n = 1'b1;
            default: ;
        endcase
    end

    assign bus.ld_ready    = ld_ready;
    assign bus.cpu_reset_n = cpu_reset_n;
    assign bus.load_done   = load_done_q;
endmodule

// File: tb/tb_cpu_mem_responder.sv
module tb_cpu_mem_responder;
    logic clk = 1'b0;
    logic reset_n;
    int   n_pass = 0;
    int   n_total = 0;

    cpu_mem_responder_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

    cpu_mem_responder #(
        .ADDR_WIDTH(16), .DATA_WIDTH(16), .IMEM_DEPTH(256), .DMEM_DEPTH(256)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we_n;
        logic [15:0] addr_1;
        logic [15:0] data_in;
        logic [15:0] addr_0;
        logic [15:0] exp_data;
        logic [15:0] exp_inst;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int n = 0;
        bus.ld_valid = 1'b1;
        bus.ld_byte  = b;
        bus.ld_last  = last;
        while (!bus.ld_ready && n < 20) begin
            tick();
            n++;
        end
        if (!bus.ld_ready) begin
            n_total++;
            $display("FAIL ld_ready_timeout: ld_ready stayed %b, expected 1", bus.ld_ready);
        end
        tick();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    task automatic pulse_start();
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
    endtask

    task automatic read_inst(input string name, input logic [15:0] a, input logic [15:0] exp);
        bus.addr_0 = a;
        #1;
        chk(name, {16'h0, bus.inst_out}, {16'h0, exp});
    endtask

    initial begin
        logic [7:0] bytes[8];
        int idx;
        int cyc;
        logic v;
        logic acc;

        reset_n      = 1'b0;
        bus.addr_0   = 16'hFFFF;
        bus.addr_1   = 16'h0;
        bus.data_in  = 16'h0;
        bus.we_n     = 1'b1;
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_byte  = 8'h0;
        bus.ld_last  = 1'b0;
        #3;
        chk("rst_ld_ready", {31'h0, bus.ld_ready}, 32'h0);
        chk("rst_cpu_reset_n", {31'h0, bus.cpu_reset_n}, 32'h0);
        chk("rst_load_done", {31'h0, bus.load_done}, 32'h0);
        chk("rst_ld_addr", {24'h0, dut.ld_addr_q}, 32'h0);
        chk("rst_hi_reg", {24'h0, dut.hi_reg_q}, 32'h0);
        chk("rst_inst_ffff", {16'h0, bus.inst_out}, 32'h0);
        #9 reset_n = 1'b1;
        tick();
        chk("idle_ld_ready", {31'h0, bus.ld_ready}, 32'h0);

        // Basic load of two words
        pulse_start();
        chk("loadhi_ld_ready", {31'h0, bus.ld_ready}, 32'h1);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h56, 1'b0);
        send_byte(8'h78, 1'b1);
        chk("release_cpu_reset_n", {31'h0, bus.cpu_reset_n}, 32'h0);
        chk("release_load_done", {31'h0, bus.load_done}, 32'h0);
        chk("release_ld_ready", {31'h0, bus.ld_ready}, 32'h0);
        tick();
        chk("run_cpu_reset_n", {31'h0, bus.cpu_reset_n}, 32'h1);
        chk("run_load_done", {31'h0, bus.load_done}, 32'h1);
        chk("run_ld_ready", {31'h0, bus.ld_ready}, 32'h0);
        read_inst("imem0_first", 16'h0000, 16'h1234);
        read_inst("imem1_first", 16'h0001, 16'h5678);

        // Data port vectors
        vecs[0] = '{"wr5_fwd",      1'b0, 16'h0005, 16'hBEEF, 16'hFFFF, 16'hBEEF, 16'h0000};
        vecs[1] = '{"rd5",          1'b1, 16'h0005, 16'h0000, 16'h0001, 16'hBEEF, 16'h5678};
        vecs[2] = '{"wr300_nofwd",  1'b0, 16'h012C, 16'h1111, 16'h0000, 16'h0000, 16'h1234};
        vecs[3] = '{"rd300",        1'b1, 16'h012C, 16'h0000, 16'h0100, 16'h0000, 16'h0000};
        vecs[4] = '{"wr255_fwd",    1'b0, 16'h00FF, 16'hA5A5, 16'hFFFF, 16'hA5A5, 16'h0000};
        vecs[5] = '{"rd255",        1'b1, 16'h00FF, 16'h0000, 16'h0000, 16'hA5A5, 16'h1234};
        vecs[6] = '{"wr261_alias",  1'b0, 16'h0105, 16'h2222, 16'h0001, 16'h0000, 16'h5678};
        vecs[7] = '{"rd5_again",    1'b1, 16'h0005, 16'h3333, 16'h0000, 16'hBEEF, 16'h1234};
        for (int i = 0; i < 8; i++) begin
            bus.we_n    = vecs[i].we_n;
            bus.addr_1  = vecs[i].addr_1;
            bus.data_in = vecs[i].data_in;
            bus.addr_0  = vecs[i].addr_0;
            #1;
            chk({vecs[i].name, "_data"}, {16'h0, bus.data_out}, {16'h0, vecs[i].exp_data});
            chk({vecs[i].name, "_inst"}, {16'h0, bus.inst_out}, {16'h0, vecs[i].exp_inst});
            tick();
        end
        bus.we_n = 1'b1;

        // Reload with ld_valid toggled randomly
        bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18};
        pulse_start();
        chk("reload_cpu_reset_n_low", {31'h0, bus.cpu_reset_n}, 32'h0);
        idx = 0;
        cyc = 0;
        while (idx < 8 && cyc < 300) begin
            v = 1'($urandom_range(0, 1));
            bus.ld_valid = v;
            bus.ld_byte  = v ? bytes[idx] : 8'hFF;
            bus.ld_last  = (idx == 7);
            acc = v && bus.ld_ready;
            tick();
            if (acc) idx++;
            cyc++;
        end
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        chk("rand_all_bytes_taken", idx, 8);
        chk("rand_release_ready", {31'h0, bus.ld_ready}, 32'h0);
        tick();
        chk("rand_run_cpu_reset_n", {31'h0, bus.cpu_reset_n}, 32'h1);
        chk("rand_ld_addr", {24'h0, dut.ld_addr_q}, 32'h4);
        read_inst("rand_w0", 16'h0000, 16'hA1B2);
        read_inst("rand_w1", 16'h0001, 16'hC3D4);
        read_inst("rand_w2", 16'h0002, 16'hE5F6);
        read_inst("rand_w3", 16'h0003, 16'h0718);

        // 257 words: the last one wraps onto address 0
        pulse_start();
        for (int w = 0; w < 256; w++) begin
            send_byte(8'(w), 1'b0);
            send_byte(~8'(w), 1'b0);
        end
        send_byte(8'hCA, 1'b0);
        send_byte(8'hFE, 1'b1);
        tick();
        chk("wrap_ld_addr", {24'h0, dut.ld_addr_q}, 32'h1);
        chk("wrap_cpu_reset_n", {31'h0, bus.cpu_reset_n}, 32'h1);
        read_inst("wrap_w0", 16'h0000, 16'hCAFE);
        read_inst("wrap_w1", 16'h0001, 16'h01FE);
        read_inst("wrap_w255", 16'h00FF, 16'hFF00);
        read_inst("wrap_w256_oor", 16'h0100, 16'h0000);

        // High byte only (ld_last ignored in LOAD_HI), then async reset
        pulse_start();
        send_byte(8'h99, 1'b1);
        chk("hi_last_ignored_ready", {31'h0, bus.ld_ready}, 32'h1);
        chk("hi_reg_captured", {24'h0, dut.hi_reg_q}, 32'h99);
        #2 reset_n = 1'b0;
        #1;
        chk("midload_rst_ready", {31'h0, bus.ld_ready}, 32'h0);
        chk("midload_rst_cpu_reset_n", {31'h0, bus.cpu_reset_n}, 32'h0);
        chk("midload_rst_hi_reg", {24'h0, dut.hi_reg_q}, 32'h0);
        chk("midload_rst_load_done", {31'h0, bus.load_done}, 32'h0);
        read_inst("midload_imem0_kept", 16'h0000, 16'hCAFE);
        read_inst("midload_imem1_kept", 16'h0001, 16'h01FE);
        #3 reset_n = 1'b1;
        tick();
        chk("post_rst_idle_ready", {31'h0, bus.ld_ready}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
